// File: rtl/inst_fetch_resp.sv
// Instruction-fetch front end: single-beat SRAM-like bus read, hold while stalled, flush-discard.
// Optional macro IFETCH_ALIGN_CHECK_EN: misaligned PCs raise the ADEL bit and skip the bus.
module inst_fetch_resp #(
    parameter int EXC_ADEL_BIT = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    input  logic [31:0] exception_type_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic [31:0] exception_type_o,
    output logic        inst_valid_o,
    output logic        inst_stall_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DISCARD
    } state_t;

    state_t      state;
    logic        flush_pend;
    logic        accept;
    logic        misalign;
    logic [31:0] adel_mask;

    assign adel_mask = 32'd1 << EXC_ADEL_BIT;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misalign = |pc_i[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign accept = pc_valid_i & ~flush_i &
                    ((state == S_IDLE) | ((state == S_DONE) & ~stall_i));

    assign inst_stall_o = pc_valid_i & ~accept;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state            <= S_IDLE;
            flush_pend       <= 1'b0;
            inst_req_o       <= 1'b0;
            inst_addr_o      <= 32'd0;
            pc_o             <= 32'd0;
            inst_o           <= 32'd0;
            exception_type_o <= 32'd0;
            inst_valid_o     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        pc_o             <= pc_i;
                        exception_type_o <= exception_type_i |
                                            (misalign ? adel_mask : 32'd0);
                        if (misalign) begin
                            state        <= S_DONE;
                            inst_o       <= 32'd0;
                            inst_valid_o <= 1'b1;
                        end else begin
                            state        <= S_REQ;
                            inst_req_o   <= 1'b1;
                            inst_addr_o  <= pc_i & ~32'd3;
                            inst_valid_o <= 1'b0;
                        end
                    end else if (flush_i || (state == S_DONE && !stall_i)) begin
                        state        <= S_IDLE;
                        inst_valid_o <= 1'b0;
                    end
                end
                S_REQ: begin
                    // A flush cannot retract an issued request; remember it until addr_ok.
                    if (inst_addr_ok_i) begin
                        inst_req_o <= 1'b0;
                        flush_pend <= 1'b0;
                        state      <= (flush_i || flush_pend) ? S_DISCARD : S_WAIT;
                    end else if (flush_i) begin
                        flush_pend <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (flush_i) begin
                        state <= inst_data_ok_i ? S_IDLE : S_DISCARD;
                    end else if (inst_data_ok_i) begin
                        inst_o       <= inst_rdata_i;
                        inst_valid_o <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DISCARD: begin
                    if (inst_data_ok_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
